sha256_stream_core: RTL and testbench

// Streaming SHA-256 compression engine for the CFU, multi-block capable.
// - Accepts 512-bit message blocks as 16 x 32-bit words over a valid/ready stream.
// - Runs ROUNDS_PER_CYCLE rounds per clock. K constants come from an internal ROM.
// - Computes W[16..63] with a 16-word sliding shift window, not FIFOs or RAM.
// - Chains H across blocks and presents a 256-bit digest over a valid/ready handshake.

---
 rtl/sha256_stream_core.sv | 202 ++++++++++++++++++++
 tb/tb_sha256_stream_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 compression core: loads a 16-word block, runs ROUNDS_PER_CYCLE
// rounds per clock over a 16-word sliding schedule window, chains H across blocks.

module sha256_round (
    input  logic [7:0][31:0]  st_i,
    input  logic [15:0][31:0] win_i,
    input  logic [31:0]       k_i,
    output logic [7:0][31:0]  st_o,
    output logic [15:0][31:0] win_o
);
    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2, s0w, s1w, w1, w14;

    // Element 0 is A, element 7 is H.
    assign {h, g, f, e, d, c, b, a} = st_i;

    assign t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g))
              + k_i + win_i[0];
    assign t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    assign st_o = {g, f, e, d + t1, c, b, a, t1 + t2};

    // Window head is W[t]; the new tail is W[t+16].
    assign w1   = win_i[1];
    assign w14  = win_i[14];
    assign s0w  = ror(w1, 7) ^ ror(w1, 18) ^ (w1 >> 3);
    assign s1w  = ror(w14, 17) ^ ror(w14, 19) ^ (w14 >> 10);
    assign win_o = {s1w + win_i[9] + s0w + win_i[0], win_i[15:1]};
endmodule

module sha256_stream_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int FEED_FORWARD     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         abort,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_word,
    input  logic         msg_first,
    output logic         busy,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest
);
    localparam int NCYC  = 64 / ROUNDS_PER_CYCLE;
    localparam int LOG2R = (ROUNDS_PER_CYCLE == 4) ? 2 : (ROUNDS_PER_CYCLE == 2) ? 1 : 0;
    localparam logic [5:0] LAST_CYC = 6'(NCYC - 1);

    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    localparam logic [64*32-1:0] K_TAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
        $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} state_t;

    state_t            state_q;
    logic [3:0]        wcnt_q;
    logic [5:0]        rnd_q;
    logic [7:0][31:0]  st_q, chain_q, st_d, ff_sum;
    logic [15:0][31:0] w_q, w_d;
    logic              msg_ready_q, busy_q, dvalid_q;
    logic [255:0]      digest_q;
    logic              msg_xfer;

    function automatic logic [255:0] pack(input logic [7:0][31:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i];
        return r;
    endfunction

    // Unrolled round chain; stage j uses K[rnd*R + j].
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
        logic [7:0][31:0]  st_in, st_nx;
        logic [15:0][31:0] win_in, win_nx;
        logic [5:0]        kidx;

        if (j == 0) begin : g_head
            assign st_in  = st_q;
            assign win_in = w_q;
        end else begin : g_tail
            assign st_in  = g_rnd[j-1].st_nx;
            assign win_in = g_rnd[j-1].win_nx;
        end

        assign kidx = (rnd_q << LOG2R) | 6'(j);

        sha256_round u_round (
            .st_i  (st_in),
            .win_i (win_in),
            .k_i   (K_TAB[{~kidx, 5'b0} +: 32]),
            .st_o  (st_nx),
            .win_o (win_nx)
        );
    end

    assign st_d = g_rnd[ROUNDS_PER_CYCLE-1].st_nx;
    assign w_d  = g_rnd[ROUNDS_PER_CYCLE-1].win_nx;

    always_comb begin
        ff_sum = '0;
        for (int i = 0; i < 8; i++) ff_sum[i] = chain_q[i] + st_q[i];
    end

    assign msg_xfer = msg_valid && msg_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            msg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            dvalid_q    <= 1'b0;
            digest_q    <= '0;
            chain_q     <= IV;
            st_q        <= '0;
            w_q         <= '0;
            wcnt_q      <= '0;
            rnd_q       <= '0;
        end else if (abort) begin
            state_q     <= IDLE;
            msg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            dvalid_q    <= 1'b0;
            chain_q     <= IV;
            wcnt_q      <= '0;
            rnd_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    msg_ready_q <= 1'b1;
                    if (msg_xfer) begin
                        w_q     <= {msg_word, w_q[15:1]};
                        st_q    <= msg_first ? IV : chain_q;
                        if (msg_first) chain_q <= IV;
                        wcnt_q  <= 4'd1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (msg_xfer) begin
                        w_q    <= {msg_word, w_q[15:1]};
                        wcnt_q <= wcnt_q + 4'd1;
                        if (wcnt_q == 4'd15) begin
                            msg_ready_q <= 1'b0;
                            rnd_q       <= '0;
                            state_q     <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    st_q  <= st_d;
                    w_q   <= w_d;
                    rnd_q <= rnd_q + 6'd1;
                    if (rnd_q == LAST_CYC) state_q <= FINAL;
                end
                FINAL: begin
                    if (FEED_FORWARD != 0) begin
                        digest_q <= pack(ff_sum);
                        chain_q  <= ff_sum;
                    end else begin
                        digest_q <= pack(st_q);
                    end
                    dvalid_q <= 1'b1;
                    state_q  <= OUT;
                end
                OUT: begin
                    if (digest_ready) begin
                        dvalid_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        msg_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign msg_ready    = msg_ready_q;
    assign busy         = busy_q;
    assign digest_valid = dvalid_q;
    assign digest       = digest_q;
endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench: four cores (R=1, R=2, R=4, R=1 without feed-forward) share one stimulus.
module tb_sha256_stream_core;
    localparam int ND = 4;
    localparam logic [255:0] IV_V = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D1   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D2   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D3A  = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] D3   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] B1   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B2   = {32'h80000000, 480'h0};
    localparam logic [511:0] B3A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B3B  = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         abort = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_first = 1'b0;
    logic         digest_ready = 1'b0;
    logic [31:0]  msg_word = '0;
    logic         mr [ND];
    logic         bz [ND];
    logic         dv [ND];
    logic [255:0] dg [ND];

    int           checks = 0;
    int           errors = 0;
    logic [255:0] exp_d [ND];
    bit           skip  [ND];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        sha256_stream_core #(
            .ROUNDS_PER_CYCLE (d == 1 ? 2 : (d == 2 ? 4 : 1)),
            .FEED_FORWARD     (d == 3 ? 0 : 1)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .abort        (abort),
            .msg_valid    (msg_valid),
            .msg_ready    (mr[d]),
            .msg_word     (msg_word),
            .msg_first    (msg_first),
            .busy         (bz[d]),
            .digest_valid (dv[d]),
            .digest_ready (digest_ready),
            .digest       (dg[d])
        );
    end

    function automatic int rpc(input int d);
        return (d == 1) ? 2 : (d == 2) ? 4 : 1;
    endfunction

    // Raw A..H of a single block started from IV is the final digest minus IV.
    function automatic logic [255:0] sub_iv(input logic [255:0] dd);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = dd[255 - 32*i -: 32] - IV_V[255 - 32*i -: 32];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic set_exp(input logic [255:0] dd, input bit skip_raw);
        for (int d = 0; d < 3; d++) begin
            exp_d[d] = dd;
            skip[d]  = 1'b0;
        end
        exp_d[3] = sub_iv(dd);
        skip[3]  = skip_raw;
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s dut%0d msg_ready", tag, d), 256'(mr[d]), '0);
            chk($sformatf("%s dut%0d busy", tag, d), 256'(bz[d]), '0);
            chk($sformatf("%s dut%0d digest_valid", tag, d), 256'(dv[d]), '0);
            chk($sformatf("%s dut%0d digest", tag, d), dg[d], '0);
        end
    endtask

    // Sends words [from, upto) of blk; msg_first is inverted on words 1..15.
    task automatic send(input logic [511:0] blk, input logic first, input int from,
                        input int upto, input bit gaps);
        for (int i = from; i < upto; i++) begin
            int n;
            if (gaps) repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                msg_valid = 1'b0;
            end
            @(negedge clk);
            msg_valid = 1'b1;
            msg_word  = blk[511 - 32*i -: 32];
            msg_first = (i == 0) ? first : ~first;
            n = 0;
            while (!mr[0] && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("word%0d ready", i), 256'(mr[0]), 256'(1));
            @(posedge clk);
        end
    endtask

    // Entered just after the edge that accepted word 15.
    task automatic wait_dig(input logic hv, input logic [31:0] hw, input logic hf,
                            input int hold, input string tag);
        int           rise [ND];
        logic [255:0] snap [ND];
        int           n;
        bit           all, mr_bad, unstable;
        n = 0;
        all = 1'b0;
        mr_bad = 1'b0;
        unstable = 1'b0;
        for (int d = 0; d < ND; d++) rise[d] = 0;
        while (!all && n < 300) begin
            @(negedge clk);
            n++;
            msg_valid    = hv;
            msg_word     = hw;
            msg_first    = hf;
            digest_ready = 1'b0;
            all = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (mr[d]) mr_bad = 1'b1;
                if (dv[d] && rise[d] == 0) rise[d] = n;
                if (!dv[d]) all = 1'b0;
            end
        end
        chk({tag, " all valid"}, 256'(all), 256'(1));
        for (int d = 0; d < ND; d++)
            chk($sformatf("%s dut%0d latency", tag, d), 256'(rise[d]), 256'(64 / rpc(d) + 2));
        for (int d = 0; d < ND; d++) snap[d] = dg[d];
        repeat (hold) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++)
                if (dg[d] !== snap[d] || !dv[d] || mr[d]) unstable = 1'b1;
        end
        if (hold > 0) chk({tag, " held stable"}, 256'(unstable), '0);
        for (int d = 0; d < ND; d++)
            if (!skip[d]) chk($sformatf("%s dut%0d digest", tag, d), dg[d], exp_d[d]);
        chk({tag, " msg_ready low"}, 256'(mr_bad), '0);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        for (int d = 0; d < ND; d++)
            chk($sformatf("%s dut%0d consumed", tag, d), 256'(dv[d]), '0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        set_exp(D1, 1'b0);
        send(B1, 1'b1, 0, 16, 1'b0);
        wait_dig(1'b0, '0, 1'b0, 0, "abc");

        digest_ready = 1'b1;
        set_exp(D2, 1'b0);
        send(B2, 1'b1, 0, 16, 1'b0);
        wait_dig(1'b0, '0, 1'b0, 0, "empty");

        set_exp(D3A, 1'b0);
        send(B3A, 1'b1, 0, 16, 1'b0);
        wait_dig(1'b0, '0, 1'b0, 0, "two-block first");
        set_exp(D3, 1'b1);
        send(B3B, 1'b0, 0, 16, 1'b0);
        wait_dig(1'b0, '0, 1'b0, 0, "two-block final");

        // Next block's word 0 is held on the bus through ROUND/FINAL/OUT.
        set_exp(D1, 1'b0);
        send(B1, 1'b1, 0, 16, 1'b1);
        wait_dig(1'b1, 32'h80000000, 1'b1, 10, "backpressure");
        set_exp(D2, 1'b0);
        send(B2, 1'b1, 1, 16, 1'b1);
        wait_dig(1'b0, '0, 1'b0, 0, "held word");

        send(B1, 1'b1, 0, 16, 1'b0);
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (29) @(negedge clk);
        abort = 1'b1;
        digest_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        digest_ready = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("abort dut%0d digest_valid", d), 256'(dv[d]), '0);
            chk($sformatf("abort dut%0d busy", d), 256'(bz[d]), '0);
            chk($sformatf("abort dut%0d msg_ready", d), 256'(mr[d]), 256'(1));
        end
        set_exp(D1, 1'b0);
        send(B1, 1'b0, 0, 16, 1'b0);
        wait_dig(1'b0, '0, 1'b0, 0, "after abort");

        send(B2, 1'b1, 0, 5, 1'b0);
        @(negedge clk);
        msg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("mid-load reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_exp(D2, 1'b0);
        send(B2, 1'b0, 0, 16, 1'b0);
        wait_dig(1'b0, '0, 1'b0, 0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
